// File: rtl/sha1_pkg.sv
// Shared SHA-1 datapath constants and the message-packer state encoding.
package sha1_pkg;

  localparam int unsigned BLOCK_W       = 512;
  localparam int unsigned MAX_MSG_BYTES = 55;
  localparam logic [7:0]  PAD_BYTE      = 8'h80;
  localparam int unsigned LEN_FIELD_W   = 64;

  typedef enum logic [2:0] {
    StIdle,
    StData,
    StPad,
    StHold,
    StDrain
  } packer_state_e;

endpackage

// File: rtl/sha1_msg_packer.sv
// Pops a length-prefixed message from the UART FIFO and assembles one padded
// 512-bit SHA-1 block, held until the consumer acknowledges it.
module sha1_msg_packer
  import sha1_pkg::*;
#(
  parameter int unsigned MAX_BYTES = MAX_MSG_BYTES,
  parameter logic [7:0]  PAD_BYTE  = sha1_pkg::PAD_BYTE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_empty,
  input  logic [7:0]         r_data,
  output logic               rd_uart,
  output logic [BLOCK_W-1:0] block,
  output logic               block_valid,
  input  logic               block_ack,
  output logic               busy,
  output logic               len_err
);

  packer_state_e state_q;
  logic [7:0]    cnt_q;
  logic [7:0]    len_q;

  // Byte n sits at bits [511-8n -: 8]; for n < 64 the low bit of that lane is {~n[5:0], 3'b0}.
  logic [8:0] data_lsb;
  logic [8:0] pad_lsb;
  assign data_lsb = {~cnt_q[5:0], 3'b000};
  assign pad_lsb  = {~len_q[5:0], 3'b000};

  // Reset is gated in so no byte is silently consumed while the packer is held.
  always_comb begin
    rd_uart = 1'b0;
    if (!rst && !rx_empty) begin
      unique case (state_q)
        StIdle, StData, StDrain: rd_uart = 1'b1;
        default:                 rd_uart = 1'b0;
      endcase
    end
  end

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      len_q       <= '0;
      block       <= '0;
      block_valid <= 1'b0;
      len_err     <= 1'b0;
    end else begin
      len_err <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!rx_empty) begin
            len_q <= r_data;
            cnt_q <= '0;
            block <= '0;
            if (r_data > 8'(MAX_BYTES)) begin
              state_q <= StDrain;
              len_err <= 1'b1;
            end else if (r_data == 8'd0) begin
              state_q <= StPad;
            end else begin
              state_q <= StData;
            end
          end
        end
        StData: begin
          if (!rx_empty) begin
            block[data_lsb +: 8] <= r_data;
            cnt_q                <= cnt_q + 8'd1;
            if (cnt_q == len_q - 8'd1) state_q <= StPad;
          end
        end
        StPad: begin
          block[pad_lsb +: 8]         <= PAD_BYTE;
          block[LEN_FIELD_W-1:0]      <= {{(LEN_FIELD_W - 11){1'b0}}, len_q, 3'b000};
          block_valid                 <= 1'b1;
          state_q                     <= StHold;
        end
        StHold: begin
          if (block_ack) begin
            block_valid <= 1'b0;
            state_q     <= StIdle;
          end
        end
        StDrain: begin
          // len_q >= 56 here, so cnt_q never needs to pass 254.
          if (!rx_empty) begin
            cnt_q <= cnt_q + 8'd1;
            if (cnt_q == len_q - 8'd1) state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_msg_packer.sv
// Scoreboard bench for sha1_msg_packer: a queue-backed FIFO model feeds bytes,
// expected blocks are queued on send and compared when block_valid rises.
module tb_sha1_msg_packer;
  import sha1_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rx_empty = 1'b1;
  logic [7:0]   r_data = 8'h00;
  logic         block_ack = 1'b0;
  logic         rd_uart;
  logic [511:0] block;
  logic         block_valid;
  logic         busy;
  logic         len_err;

  sha1_msg_packer dut (
    .clk         (clk),
    .rst         (rst),
    .rx_empty    (rx_empty),
    .r_data      (r_data),
    .rd_uart     (rd_uart),
    .block       (block),
    .block_valid (block_valid),
    .block_ack   (block_ack),
    .busy        (busy),
    .len_err     (len_err)
  );

  always #5 clk = ~clk;

  logic [7:0]   fifo[$];
  logic [511:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_pop = 0;
  int pops     = 0;
  int hold     = 0;
  int lerr     = 0;
  int ack_wait = 0;
  bit gap_en    = 1'b0;
  bit gap       = 1'b0;
  bit hold_off  = 1'b1;
  bit after_ack = 1'b0;
  bit lerr_prev = 1'b0;

  task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  function automatic logic [511:0] pad_block(input logic [7:0] msg[$]);
    logic [511:0] b;
    b = '0;
    for (int i = 0; i < msg.size(); i++) b[511-8*i -: 8] = msg[i];
    b[511-8*msg.size() -: 8] = 8'h80;
    b[63:0] = 64'(msg.size() * 8);
    return b;
  endfunction

  task automatic queue_msg(input logic [7:0] msg[$], input logic [511:0] exp);
    fifo.push_back(8'(msg.size()));
    foreach (msg[i]) fifo.push_back(msg[i]);
    exp_q.push_back(exp);
  endtask

  // One clock: sample before the edge, observe #1 after it, then drive inputs.
  task automatic tick();
    logic rd_s, empty_s, valid_s;
    rd_s    = rd_uart;
    empty_s = rx_empty;
    valid_s = block_valid;
    if (empty_s)               check("rd_while_empty", 512'(rd_s), 512'(0));
    if (valid_s)               check("rd_in_hold", 512'(rd_s), 512'(0));
    if (after_ack && !empty_s) check("rd_after_ack", 512'(rd_s), 512'(1));
    @(posedge clk);
    #1;
    cyc++;
    if (rd_s) begin
      void'(fifo.pop_front());
      pops++;
      last_pop = cyc;
    end
    if (block_valid && !valid_s) begin
      if (exp_q.size() == 0) begin
        check("spurious_block", 512'(1), 512'(0));
      end else begin
        check("block", block, exp_q.pop_front());
        check("pad_latency", 512'(cyc - last_pop), 512'(1));
      end
      hold = 0;
    end
    if (block_valid) hold++;
    if (valid_s && !block_valid)
      check("valid_width", 512'(hold), 512'((ack_wait == 0) ? 1 : ack_wait));
    after_ack = valid_s && !block_valid;
    if (len_err) lerr++;
    if (len_err && lerr_prev) check("len_err_width", 512'(1), 512'(0));
    lerr_prev = len_err;
    block_ack = (ack_wait == 0) || (block_valid && hold >= ack_wait);
    gap       = gap_en ? ~gap : 1'b0;
    rx_empty  = hold_off || (fifo.size() == 0) || gap;
    r_data    = (fifo.size() != 0) ? fifo[0] : 8'h00;
    #1;
  endtask

  task automatic run_until_done(input int budget);
    int n;
    n = 0;
    while (!(fifo.size() == 0 && exp_q.size() == 0 && !busy && !block_valid) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check("timeout", 512'(1), 512'(0));
  endtask

  initial begin
    logic [7:0] msg[$];
    int p0;

    repeat (2) tick();
    rst = 1'b0;
    #1;
    check("reset_rd_uart", 512'(rd_uart), 512'(0));
    check("reset_block", block, '0);
    check("reset_valid", 512'(block_valid), 512'(0));
    check("reset_busy", 512'(busy), 512'(0));
    check("reset_len_err", 512'(len_err), 512'(0));
    hold_off = 1'b0;

    // "abc"
    p0  = pops;
    msg = '{8'h61, 8'h62, 8'h63};
    queue_msg(msg, {32'h61626380, 416'b0, 64'h18});
    run_until_done(100);
    check("abc_pops", 512'(pops - p0), 512'(4));

    // Empty message
    p0 = pops;
    msg.delete();
    queue_msg(msg, {8'h80, 504'b0});
    run_until_done(100);
    check("empty_pops", 512'(pops - p0), 512'(1));

    // Maximum length: 55 x 'A'
    p0 = pops;
    msg.delete();
    for (int i = 0; i < 55; i++) msg.push_back(8'h41);
    queue_msg(msg, {{55{8'h41}}, 8'h80, 64'h1B8});
    run_until_done(300);
    check("max_pops", 512'(pops - p0), 512'(56));

    // Bad length 0x38 drains 56 junk bytes, then "Z" must frame correctly
    p0 = pops;
    fifo.push_back(8'h38);
    for (int i = 0; i < 56; i++) fifo.push_back(8'(i * 7 + 1));
    msg = '{8'h5A};
    queue_msg(msg, {16'h5A80, 432'b0, 64'h8});
    run_until_done(300);
    check("drain_pops", 512'(pops - p0), 512'(59));
    check("drain_len_err", 512'(lerr), 512'(1));

    // Back-pressure: FIFO gaps and a slow consumer, with the next message queued
    p0       = pops;
    gap_en   = 1'b1;
    ack_wait = 10;
    msg      = '{8'h61, 8'h62, 8'h63};
    queue_msg(msg, {32'h61626380, 416'b0, 64'h18});
    msg      = '{8'h42};
    queue_msg(msg, {16'h4280, 432'b0, 64'h8});
    run_until_done(300);
    check("bp_pops", 512'(pops - p0), 512'(6));
    gap_en   = 1'b0;
    ack_wait = 0;

    // Back-to-back random messages
    for (int m = 0; m < 3; m++) begin
      msg.delete();
      for (int i = 0; i < $urandom_range(55, 1); i++) msg.push_back(8'($urandom));
      queue_msg(msg, pad_block(msg));
    end
    run_until_done(500);

    // Reset after two of five data bytes
    p0 = pops;
    fifo.push_back(8'h05);
    for (int i = 0; i < 5; i++) fifo.push_back(8'h11 * 8'(i + 1));
    for (int n = 0; n < 50 && (pops - p0) < 3; n++) tick();
    check("pre_reset_pops", 512'(pops - p0), 512'(3));
    hold_off = 1'b1;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mid_reset_rd_uart", 512'(rd_uart), 512'(0));
    check("mid_reset_block", block, '0);
    check("mid_reset_valid", 512'(block_valid), 512'(0));
    check("mid_reset_busy", 512'(busy), 512'(0));
    check("mid_reset_len_err", 512'(len_err), 512'(0));
    fifo.delete();
    hold_off = 1'b0;
    msg      = '{8'hFF};
    queue_msg(msg, {16'hFF80, 432'b0, 64'h8});
    run_until_done(100);

    check("total_len_err", 512'(lerr), 512'(1));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
